// File: rtl/proj_switch_ctrl.sv
// proj_switch_ctrl: Wishbone-controlled owner of the shared user pad bank.
// Selects one of NPROJ user projects onto the pads and sequences every
// change as gate -> switch -> hold-in-reset -> release so that no project
// ever drives the pads while the mux select moves. Unselected projects are
// always held in reset.
module proj_switch_ctrl #(
    parameter int          NPROJ        = 8,
    parameter int          SEL_W        = 3,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          GUARD_CYCLES = 4,
    parameter int          RESET_CYCLES = 16,
    parameter int          DEFAULT_PROJ = 0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic [SEL_W-1:0] proj_sel_o,
    output logic [NPROJ-1:0] proj_rst_o,
    output logic             io_gate_o,
    output logic             busy_o
);

    // Counter is sized for the longer of the two phases; it is loaded with
    // (phase length - 1) and the phase ends on the edge where it reads zero.
    localparam int CNT_MAX = (GUARD_CYCLES > RESET_CYCLES) ? GUARD_CYCLES : RESET_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [SEL_W-1:0] DEF_SEL    = SEL_W'(DEFAULT_PROJ);
    localparam logic [7:0]       NPROJ_B    = 8'(NPROJ);

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_RSTCTL = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // One-hot decode of a project index onto the per-project reset vector.
    function automatic logic [NPROJ-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NPROJ-1:0] oh;
        oh = {NPROJ{1'b0}};
        for (int i = 0; i < NPROJ; i++) begin
            oh[i] = (sel == SEL_W'(i));
        end
        return oh;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  tgt_q, tgt_d;
    logic [SEL_W-1:0]  ctrl_q, ctrl_d;
    logic              err_q, err_d;
    logic              drop_q, drop_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic [NPROJ-1:0]  prst_q, prst_d;
    logic              gate_q, gate_d;
    logic              busy_q, busy_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic              acc_s;
    logic [3:0]        off_s;
    logic              wr_ctrl_s;
    logic              wr_rst_s;
    logic              rd_status_s;
    logic              req_oor_s;
    logic              idle_s;
    logic              start_s;
    logic [SEL_W-1:0]  start_tgt_s;
    logic              err_set_s;
    logic              drop_set_s;
    logic [31:0]       rd_data_s;

    // Write-data and byte-select bits that carry no function in this block.
    logic              unused_s;
    assign unused_s = ^{wbs_sel_i[3:1], wbs_dat_i[31:8]};

    assign off_s = wbs_adr_i[3:0];

    // Decode one accepted access and derive the sequence-start and flag-set events.
    always_comb begin
        acc_s       = wbs_cyc_i & wbs_stb_i & ~ack_q &
                      (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        wr_ctrl_s   = acc_s & wbs_we_i & (off_s == OFF_CTRL)   & wbs_sel_i[0];
        wr_rst_s    = acc_s & wbs_we_i & (off_s == OFF_RSTCTL) & wbs_sel_i[0] & wbs_dat_i[0];
        rd_status_s = acc_s & ~wbs_we_i & (off_s == OFF_STATUS);
        // The whole low byte is range-checked so that e.g. 9 is rejected
        // rather than silently aliasing onto project 1.
        req_oor_s   = (wbs_dat_i[7:0] >= NPROJ_B);
        idle_s      = (state_q == ST_IDLE);
        start_s     = idle_s & ((wr_ctrl_s & ~req_oor_s) | wr_rst_s);
        err_set_s   = wr_ctrl_s & req_oor_s;
        drop_set_s  = ~idle_s & ((wr_ctrl_s & ~req_oor_s) | wr_rst_s);
        if (wr_ctrl_s) begin
            start_tgt_s = wbs_dat_i[SEL_W-1:0];
        end else begin
            start_tgt_s = sel_q;
        end
    end

    // Read-data mux for the register window.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (off_s)
            OFF_CTRL: begin
                rd_data_s[SEL_W-1:0] = ctrl_q;
            end
            OFF_STATUS: begin
                rd_data_s[SEL_W-1:0] = sel_q;
                rd_data_s[8]         = busy_q;
                rd_data_s[9]         = err_q;
                rd_data_s[10]        = drop_q;
            end
            default: begin
                rd_data_s = 32'h0000_0000;
            end
        endcase
    end

    // Register-file next state: request latch, sticky flags, ack and read data.
    always_comb begin
        ctrl_d = ctrl_q;
        err_d  = err_q;
        drop_d = drop_q;
        ack_d  = acc_s;
        dat_d  = 32'h0000_0000;

        if (wr_ctrl_s & ~req_oor_s & idle_s) begin
            ctrl_d = wbs_dat_i[SEL_W-1:0];
        end else begin
            ctrl_d = ctrl_q;
        end

        // A flag raised on the same edge as a STATUS read survives the clear.
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (rd_status_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        if (drop_set_s) begin
            drop_d = 1'b1;
        end else if (rd_status_s) begin
            drop_d = 1'b0;
        end else begin
            drop_d = drop_q;
        end

        if (acc_s & ~wbs_we_i) begin
            dat_d = rd_data_s;
        end else begin
            dat_d = 32'h0000_0000;
        end
    end

    // Handover FSM next state; the mux select only moves on the GATE->HOLD edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        tgt_d   = tgt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_GATE;
                    cnt_d   = GUARD_LOAD;
                    tgt_d   = start_tgt_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GATE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_HOLD;
                    sel_d   = tgt_q;
                    cnt_d   = RESET_LOAD;
                end else begin
                    cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = RESET_LOAD;
            end
        endcase
    end

    // Pad-side outputs follow the next state so they change on the same edge.
    always_comb begin
        if (state_d == ST_IDLE) begin
            prst_d = ~sel_onehot(sel_d);
            gate_d = 1'b0;
            busy_d = 1'b0;
        end else begin
            prst_d = {NPROJ{1'b1}};
            gate_d = 1'b1;
            busy_d = 1'b1;
        end
    end

    // State and output registers; reset parks the block in HOLD on the default project.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_HOLD;
            cnt_q   <= RESET_LOAD;
            sel_q   <= DEF_SEL;
            tgt_q   <= DEF_SEL;
            ctrl_q  <= DEF_SEL;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= 32'h0000_0000;
            prst_q  <= {NPROJ{1'b1}};
            gate_q  <= 1'b1;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            tgt_q   <= tgt_d;
            ctrl_q  <= ctrl_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            prst_q  <= prst_d;
            gate_q  <= gate_d;
            busy_q  <= busy_d;
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign proj_sel_o = sel_q;
    assign proj_rst_o = prst_q;
    assign io_gate_o  = gate_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_proj_switch_ctrl.sv
// Self-checking bench for proj_switch_ctrl: bus reads are scored against a
// queue of expected read data, sequence timing is checked cycle by cycle.
module tb_proj_switch_ctrl;

    localparam int          GUARD = 4;
    localparam int          HOLD  = 16;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    logic        clk;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [2:0]  psel;
    logic [7:0]  prst;
    logic        gate;
    logic        busy;

    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [2:0]  prev_sel;
    int          n;

    proj_switch_ctrl dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .proj_sel_o (psel),
        .proj_rst_o (prst),
        .io_gate_o  (gate),
        .busy_o     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count a comparison and report it if it miscompares.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One classic single-cycle Wishbone strobe, spaced from the previous one.
    task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d);
        tick();
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = 4'hF;
        tick();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = 32'h0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input string tag);
        exp_q.push_back(32'h0);
        tag_q.push_back({tag, "_wdat"});
        wb_access(a, 1'b1, d);
        check_val({tag, "_ack"}, {31'b0, ack}, 32'd1);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        wb_access(a, 1'b0, 32'h0);
        check_val({tag, "_ack"}, {31'b0, ack}, 32'd1);
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        check_val("idle_reached", {31'b0, busy}, 32'd0);
    endtask

    // Walk a running sequence from E0+1: old select for GUARD cycles, then new.
    task automatic measure_seq(input logic [2:0] old_p, input logic [2:0] new_p, output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            check_val("seq_sel", {29'b0, psel}, (cnt < GUARD) ? {29'b0, old_p} : {29'b0, new_p});
            check_val("seq_gate_rst", {23'b0, gate, prst}, 32'h1FF);
            tick();
            cnt++;
        end
    endtask

    // Scoreboard: every ack pops the next expected read-data word.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_ack", {31'b0, ack}, 32'd0);
            end else begin
                check_val(tag_q.pop_front(), rdat, exp_q.pop_front());
            end
        end
    end

    // Any movement of the select must happen with pads gated and all projects in reset.
    always @(negedge clk) begin
        if (psel !== prev_sel) begin
            check_val("sel_change_gated", {23'b0, gate, prst}, 32'h1FF);
        end
        prev_sel <= psel;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; wdat = 32'h0; prev_sel = 3'd0;

        // 1: reset state, release, 16 cycles of HOLD
        tick(); tick();
        check_val("rst_sel",  {29'b0, psel}, 32'd0);
        check_val("rst_prst", {24'b0, prst}, 32'hFF);
        check_val("rst_gate", {31'b0, gate}, 32'd1);
        check_val("rst_busy", {31'b0, busy}, 32'd1);
        check_val("rst_ack",  {31'b0, ack},  32'd0);
        rst = 1'b0;
        wait_idle(n);
        check_val("rel_cycles", n, HOLD);
        check_val("rel_sel",  {29'b0, psel}, 32'd0);
        check_val("rel_prst", {24'b0, prst}, 32'hFE);
        check_val("rel_gate", {31'b0, gate}, 32'd0);
        wb_read(BASE + 32'h4, 32'h000, "status_after_rst");

        // 2: switch to project 5
        wb_write(BASE + 32'h0, 32'd5, "ctrl5");
        check_val("e0_prst", {24'b0, prst}, 32'hFF);
        check_val("e0_gate", {31'b0, gate}, 32'd1);
        check_val("e0_busy", {31'b0, busy}, 32'd1);
        measure_seq(3'd0, 3'd5, n);
        check_val("sw5_busy_cycles", n, GUARD + HOLD);
        check_val("sw5_sel",  {29'b0, psel}, 32'd5);
        check_val("sw5_prst", {24'b0, prst}, 32'hDF);
        check_val("sw5_gate", {31'b0, gate}, 32'd0);
        wb_read(BASE + 32'h0, 32'd5, "ctrl_rd5");

        // 3: out-of-range request sets ERR, STATUS read clears it
        wb_write(BASE + 32'h0, 32'd9, "ctrl9");
        check_val("oor_busy", {31'b0, busy}, 32'd0);
        check_val("oor_sel",  {29'b0, psel}, 32'd5);
        wb_read(BASE + 32'h4, 32'h205, "status_err");
        wb_read(BASE + 32'h4, 32'h005, "status_err_clr");
        wb_read(BASE + 32'h0, 32'd5, "ctrl_rd_after_oor");

        // 4: second write while busy is acked but dropped
        wb_write(BASE + 32'h0, 32'd3, "ctrl3");
        wb_write(BASE + 32'h0, 32'd6, "ctrl6_busy");
        check_val("drop_still_busy", {31'b0, busy}, 32'd1);
        wait_idle(n);
        check_val("drop_sel",  {29'b0, psel}, 32'd3);
        check_val("drop_prst", {24'b0, prst}, 32'hF7);
        wb_read(BASE + 32'h4, 32'h403, "status_drop");
        wb_read(BASE + 32'h0, 32'd3, "ctrl_rd3");

        // 5: soft reset of the active project
        wb_write(BASE + 32'h8, 32'd1, "rstctl");
        measure_seq(3'd3, 3'd3, n);
        check_val("srst_busy_cycles", n, GUARD + HOLD);
        check_val("srst_prst", {24'b0, prst}, 32'hF7);
        wb_read(BASE + 32'h8, 32'd0, "rstctl_rd");
        wb_read(BASE + 32'hC, 32'd0, "unused_off_rd");

        // 6: asynchronous reset during HOLD of a switch to 5
        wb_write(BASE + 32'h0, 32'd5, "ctrl5_b");
        repeat (GUARD + 2) tick();
        check_val("hold_sel", {29'b0, psel}, 32'd5);
        #2 rst = 1'b1;
        #1;
        check_val("async_sel",  {29'b0, psel}, 32'd0);
        check_val("async_gate", {31'b0, gate}, 32'd1);
        check_val("async_busy", {31'b0, busy}, 32'd1);
        check_val("async_prst", {24'b0, prst}, 32'hFF);
        tick(); tick();
        rst = 1'b0;
        wait_idle(n);
        check_val("rel2_cycles", n, HOLD);
        check_val("rel2_sel",  {29'b0, psel}, 32'd0);
        check_val("rel2_prst", {24'b0, prst}, 32'hFE);
        wb_read(BASE + 32'h4, 32'h000, "status_after_rst2");
        wb_read(BASE + 32'h0, 32'd0, "ctrl_after_rst2");

        // Accesses outside the window get no ack
        wb_access(BASE + 32'h10, 1'b0, 32'h0);
        check_val("oow_ack_a", {31'b0, ack}, 32'd0);
        wb_access(32'h2000_0004, 1'b0, 32'h0);
        check_val("oow_ack_b", {31'b0, ack}, 32'd0);
        tick(); tick();
        check_val("sb_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
